// File: rtl/fdiv_issue_ctrl.sv
// Issue/write-back sequencer for a multi-cycle FP divider: latches operands, handshakes the divider, stalls dependent IF/ID traffic.
// Optional watchdog enabled by defining FDIV_TIMEOUT_EN.
module fdiv_issue_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 40
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        id_fdiv,
  input  logic [31:0] id_a,
  input  logic [31:0] id_b,
  input  logic [1:0]  id_rm,
  input  logic [4:0]  id_fd,
  input  logic [4:0]  id_fs,
  input  logic [4:0]  id_ft,
  input  logic        id_fs_rd,
  input  logic        id_ft_rd,
  input  logic        id_fwr,
  input  logic [4:0]  id_fwd,
  input  logic        pipe_flush,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic [1:0]  div_rm,
  output logic        div_start,
  output logic        div_enable,
  input  logic        div_busy,
  input  logic [31:0] div_s,
  output logic        pipe_stall,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        div_err
);

  localparam logic [31:0] QNAN = 32'h7fc0_0000;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_BUSY   = 2'd2,
    S_WB     = 2'd3
  } state_t;

  state_t      state_q, state_n;
  logic [31:0] pend_a_q, pend_b_q, res_q;
  logic [1:0]  pend_rm_q;
  logic [4:0]  pend_fd_q;
  logic        div_start_q, div_enable_q, wb_we_q;
  logic        accept, capture, tmo_fire;
  logic        hazard_c;

`ifdef FDIV_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             tmo_hit;
  logic             div_err_q;

  assign tmo_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  // Next-state decode; a normal completion in BUSY wins over a same-cycle watchdog expiry
  always_comb begin
    state_n  = state_q;
    accept   = 1'b0;
    capture  = 1'b0;
    tmo_fire = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (id_fdiv && !pipe_flush) begin
          accept  = 1'b1;
          state_n = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
`ifdef FDIV_TIMEOUT_EN
        if (tmo_hit) begin
          tmo_fire = 1'b1;
          state_n  = S_WB;
        end else
`endif
        if (div_busy) state_n = S_BUSY;
      end
      S_BUSY: begin
        if (!div_busy) begin
          capture = 1'b1;
          state_n = S_WB;
        end
`ifdef FDIV_TIMEOUT_EN
        else if (tmo_hit) begin
          tmo_fire = 1'b1;
          state_n  = S_WB;
        end
`endif
      end
      S_WB:    state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_n;
  end

  // Pending operands and result register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pend_a_q  <= '0;
      pend_b_q  <= '0;
      pend_rm_q <= '0;
      pend_fd_q <= '0;
      res_q     <= '0;
    end else begin
      if (accept) begin
        pend_a_q  <= id_a;
        pend_b_q  <= id_b;
        pend_rm_q <= id_rm;
        pend_fd_q <= id_fd;
      end
      if (capture)       res_q <= div_s;
      else if (tmo_fire) res_q <= QNAN;
    end
  end

  // Outputs registered from the next state so they align with the state they describe
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      div_start_q  <= 1'b0;
      div_enable_q <= 1'b0;
      wb_we_q      <= 1'b0;
    end else begin
      div_start_q  <= (state_n == S_LAUNCH);
      div_enable_q <= (state_n != S_IDLE);
      wb_we_q      <= (state_n == S_WB);
    end
  end

`ifdef FDIV_TIMEOUT_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q     <= '0;
      div_err_q <= 1'b0;
    end else begin
      div_err_q <= tmo_fire;
      if (accept)
        cnt_q <= '0;
      else if (state_q == S_LAUNCH || state_q == S_BUSY)
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign div_err = div_err_q;
`else
  assign div_err = 1'b0;
`endif

  // Decode-stage hazard against the in-flight destination register
  always_comb begin
    hazard_c = id_fdiv
             | (id_fs_rd && (id_fs  == pend_fd_q))
             | (id_ft_rd && (id_ft  == pend_fd_q))
             | (id_fwr   && (id_fwd == pend_fd_q));
  end

  assign pipe_stall = (state_q != S_IDLE) && !pipe_flush && hazard_c;

  assign div_a      = pend_a_q;
  assign div_b      = pend_b_q;
  assign div_rm     = pend_rm_q;
  assign div_start  = div_start_q;
  assign div_enable = div_enable_q;
  assign wb_we      = wb_we_q;
  assign wb_rd      = pend_fd_q;
  assign wb_data    = res_q;

endmodule

// File: tb/tb_fdiv_issue_ctrl.sv
// Directed self-checking bench for fdiv_issue_ctrl: hazard vector table plus hand-written multi-cycle sequences.
module tb_fdiv_issue_ctrl;

  logic        clock = 1'b0;
  logic        resetn;
  logic        id_fdiv, id_fs_rd, id_ft_rd, id_fwr, pipe_flush;
  logic [31:0] id_a, id_b, div_s;
  logic [1:0]  id_rm;
  logic [4:0]  id_fd, id_fs, id_ft, id_fwd;
  logic [31:0] div_a, div_b, wb_data;
  logic [1:0]  div_rm;
  logic        div_start, div_enable, div_busy, pipe_stall, wb_we, div_err;
  logic [4:0]  wb_rd;

  int n_chk  = 0;
  int n_pass = 0;
  int wb_cnt = 0;
  int c0;

  typedef struct {
    logic       fdiv;
    logic       fs_rd;
    logic [4:0] fs;
    logic       ft_rd;
    logic [4:0] ft;
    logic       fwr;
    logic [4:0] fwd;
    logic       flush;
    logic       exp_stall;
  } hz_vec_t;

  hz_vec_t tbl [10];

  fdiv_issue_ctrl #(.TIMEOUT_CYCLES(40)) dut (
    .clock(clock), .resetn(resetn),
    .id_fdiv(id_fdiv), .id_a(id_a), .id_b(id_b), .id_rm(id_rm), .id_fd(id_fd),
    .id_fs(id_fs), .id_ft(id_ft), .id_fs_rd(id_fs_rd), .id_ft_rd(id_ft_rd),
    .id_fwr(id_fwr), .id_fwd(id_fwd), .pipe_flush(pipe_flush),
    .div_a(div_a), .div_b(div_b), .div_rm(div_rm), .div_start(div_start),
    .div_enable(div_enable), .div_busy(div_busy), .div_s(div_s),
    .pipe_stall(pipe_stall), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .div_err(div_err)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (wb_we === 1'b1) wb_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Plays the divider: acknowledges after ack cycles of start, stays busy, then returns res; ends in WB cycle
  task automatic serve(input int ack, input int len, input logic [31:0] res, input string nm);
    int starts;
    starts = 0;
    for (int k = 0; k < ack; k++) begin
      if (div_start) starts++;
      if (k == ack - 1) div_busy = 1'b1;
      tick();
    end
    chk({nm, " start_cycles"}, 32'(starts), 32'(ack));
    chk({nm, " start_off_busy"}, 32'(div_start), 32'd0);
    for (int k = 0; k < len - 1; k++) tick();
    div_busy = 1'b0;
    div_s    = res;
    tick();
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " div_start"},  32'(div_start),  32'd0);
    chk({nm, " div_enable"}, 32'(div_enable), 32'd0);
    chk({nm, " pipe_stall"}, 32'(pipe_stall), 32'd0);
    chk({nm, " wb_we"},      32'(wb_we),      32'd0);
    chk({nm, " wb_rd"},      32'(wb_rd),      32'd0);
    chk({nm, " wb_data"},    wb_data,         32'd0);
    chk({nm, " div_a"},      div_a,           32'd0);
    chk({nm, " div_b"},      div_b,           32'd0);
    chk({nm, " div_rm"},     32'(div_rm),     32'd0);
    chk({nm, " div_err"},    32'(div_err),    32'd0);
  endtask

  initial begin
    //            fdiv fs_rd fs  ft_rd ft  fwr fwd flush exp
    tbl[0] = '{1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 5'd7, 1'b0, 5'd7, 1'b0, 5'd7, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 5'd0, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd6, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0};
    tbl[9] = '{1'b1, 1'b0, 5'd0, 1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0};

    resetn = 1'b1;
    id_fdiv = 0; id_a = 0; id_b = 0; id_rm = 0; id_fd = 0;
    id_fs = 0; id_ft = 0; id_fs_rd = 0; id_ft_rd = 0; id_fwr = 0; id_fwd = 0;
    pipe_flush = 0; div_busy = 0; div_s = 0;
    #2 resetn = 1'b0;
    tick(); tick();
    chk_all_zero("reset");
    resetn = 1'b1;
    tick();

    // 6.0 / 2.0 into f7
    c0 = wb_cnt;
    id_a = 32'h40C0_0000; id_b = 32'h4000_0000; id_rm = 2'd2; id_fd = 5'd7; id_fdiv = 1'b1;
    tick();
    chk("div launch start",  32'(div_start),  32'd1);
    chk("div launch enable", 32'(div_enable), 32'd1);
    chk("div launch a",      div_a,           32'h40C0_0000);
    chk("div launch b",      div_b,           32'h4000_0000);
    chk("div launch rm",     32'(div_rm),     32'd2);
    chk("div launch stall",  32'(pipe_stall), 32'd1);
    id_fdiv = 1'b0; id_a = 0; id_b = 0; id_rm = 0; id_fd = 0;
    div_busy = 1'b1;
    tick();
    chk("div busy start_off", 32'(div_start), 32'd0);
    chk("div busy a_held",    div_a,          32'h40C0_0000);

    for (int i = 0; i < 10; i++) begin
      id_fdiv = tbl[i].fdiv; id_fs_rd = tbl[i].fs_rd; id_fs = tbl[i].fs;
      id_ft_rd = tbl[i].ft_rd; id_ft = tbl[i].ft; id_fwr = tbl[i].fwr;
      id_fwd = tbl[i].fwd; pipe_flush = tbl[i].flush;
      #1;
      chk($sformatf("hazard vec%0d", i), 32'(pipe_stall), 32'(tbl[i].exp_stall));
    end
    id_fdiv = 0; id_ft_rd = 0; id_fwr = 0; pipe_flush = 0;
    id_fs_rd = 1'b1; id_fs = 5'd7;

    for (int k = 0; k < 8; k++) tick();
    chk("div still busy", 32'(div_enable), 32'd1);
    tick();
    div_busy = 1'b0; div_s = 32'h4040_0000;
    tick();
    chk("div wb_we",    32'(wb_we),      32'd1);
    chk("div wb_rd",    32'(wb_rd),      32'd7);
    chk("div wb_data",  wb_data,         32'h4040_0000);
    chk("div wb_stall", 32'(pipe_stall), 32'd1);
    chk("div wb_err",   32'(div_err),    32'd0);
    tick();
    chk("div idle wb_we",  32'(wb_we),      32'd0);
    chk("div idle stall",  32'(pipe_stall), 32'd0);
    chk("div idle enable", 32'(div_enable), 32'd0);
    id_fs_rd = 0; id_fs = 0;
    repeat (3) tick();
    chk("div write count", 32'(wb_cnt - c0), 32'd1);

    // Back-to-back with id_fdiv held high
    c0 = wb_cnt;
    id_a = 32'h3F80_0000; id_b = 32'h3F80_0000; id_fd = 5'd3; id_fdiv = 1'b1;
    tick();
    serve(1, 3, 32'h1111_1111, "b2b1");
    chk("b2b1 wb_we",   32'(wb_we), 32'd1);
    chk("b2b1 wb_rd",   32'(wb_rd), 32'd3);
    chk("b2b1 wb_data", wb_data,    32'h1111_1111);
    id_fd = 5'd9;
    tick();
    chk("b2b gap start", 32'(div_start), 32'd0);
    chk("b2b gap wb_we", 32'(wb_we),     32'd0);
    tick();
    chk("b2b second start", 32'(div_start), 32'd1);
    id_fdiv = 1'b0;
    serve(1, 2, 32'h2222_2222, "b2b2");
    chk("b2b2 wb_rd",   32'(wb_rd), 32'd9);
    chk("b2b2 wb_data", wb_data,    32'h2222_2222);
    repeat (4) tick();
    chk("b2b write count", 32'(wb_cnt - c0), 32'd2);
    chk("b2b idle enable", 32'(div_enable), 32'd0);

    // Slow acknowledge, with a flush arriving after acceptance
    c0 = wb_cnt;
    id_fd = 5'd12; id_fdiv = 1'b1;
    tick();
    id_fdiv = 1'b0; pipe_flush = 1'b1;
    serve(3, 2, 32'h3333_3333, "slow");
    chk("slow wb_we",   32'(wb_we), 32'd1);
    chk("slow wb_rd",   32'(wb_rd), 32'd12);
    chk("slow wb_data", wb_data,    32'h3333_3333);
    tick();
    repeat (2) tick();
    chk("slow write count", 32'(wb_cnt - c0), 32'd1);

    // Flushed request in IDLE is never accepted
    id_fdiv = 1'b1;
    tick(); tick();
    chk("flush idle start",  32'(div_start),  32'd0);
    chk("flush idle enable", 32'(div_enable), 32'd0);
    id_fdiv = 1'b0; pipe_flush = 1'b0;

    // Asynchronous reset mid-BUSY
    c0 = wb_cnt;
    id_a = 32'h0000_1234; id_b = 32'h0000_5678; id_rm = 2'd1; id_fd = 5'd5; id_fdiv = 1'b1;
    tick();
    div_busy = 1'b1;
    tick(); tick();
    chk("rst pre stall",  32'(pipe_stall), 32'd1);
    chk("rst pre enable", 32'(div_enable), 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk_all_zero("rst mid");
    id_fdiv = 1'b0; div_busy = 1'b0;
    tick();
    resetn = 1'b1;
    repeat (10) tick();
    chk("rst no write",   32'(wb_cnt - c0), 32'd0);
    chk("rst idle enable", 32'(div_enable), 32'd0);

    // Divider stuck busy
    c0 = wb_cnt;
    id_fd = 5'd4; id_fdiv = 1'b1;
    tick();
    id_fdiv = 1'b0; div_busy = 1'b1;
`ifdef FDIV_TIMEOUT_EN
    repeat (39) tick();
    chk("tmo pre wb_we", 32'(wb_we), 32'd0);
    tick();
    chk("tmo wb_we",   32'(wb_we),   32'd1);
    chk("tmo wb_rd",   32'(wb_rd),   32'd4);
    chk("tmo wb_data", wb_data,      32'h7fc0_0000);
    chk("tmo div_err", 32'(div_err), 32'd1);
    tick();
    chk("tmo err pulse", 32'(div_err), 32'd0);
    chk("tmo wb_we off", 32'(wb_we),   32'd0);
    div_busy = 1'b0;
    repeat (3) tick();
    chk("tmo write count", 32'(wb_cnt - c0), 32'd1);
`else
    repeat (60) tick();
    chk("hang no write", 32'(wb_cnt - c0), 32'd0);
    chk("hang enable",   32'(div_enable), 32'd1);
    chk("hang div_err",  32'(div_err),    32'd0);
    div_busy = 1'b0;
    #2 resetn = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
